wddl_xor_tree_pipe: RTL and testbench

Parametrised, pipelined N-input WDDL dual-rail XOR reduction. It replaces the fixed-arity, purely combinational xor chains with one block generalised in input count and width. It adds registered tree levels, an internal precharge/evaluate phase controller, token valid tracking and dual-rail code-error detection. It is used wherever wide AES XOR reductions (MixColumns, key schedule) need a timing break while preserving the precharge wave.

---
 rtl/wddl_pkg.sv | 28 ++
 rtl/wddl_xor_tree_pipe_if.sv | 48 ++++
 rtl/wddl_phase_ctrl.sv | 40 ++++
 rtl/wddl_xor2.sv | 17 +
 rtl/wddl_xor_tree_pipe.sv | 135 +++++++++++++
 tb/tb_wddl_xor_tree_pipe.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wddl_pkg.sv
// Shared definitions for the pipelined WDDL dual-rail XOR tree.
// Phase encodings, operand-count bounds and tree sizing helpers.
package wddl_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_PRE  = 2'b01,
    PH_EVAL = 2'b10
  } phase_t;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

  function automatic int half_up(input int n);
    return (n + 1) / 2;
  endfunction

  // Element count entering tree level k for n operands.
  function automatic int level_size(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) begin
      c = half_up(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/wddl_xor_tree_pipe_if.sv
// Operand/result bundle of the WDDL XOR tree.
// master drives operands and control, slave returns results and flags.
interface wddl_xor_tree_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 6
);

  logic                    en;
  logic                    in_valid;
  logic [NUM_IN*WIDTH-1:0] d_p_in;
  logic [NUM_IN*WIDTH-1:0] d_n_in;
  logic                    err_clr;
  logic                    phase_eval;
  logic [WIDTH-1:0]        d_p_out;
  logic [WIDTH-1:0]        d_n_out;
  logic                    out_valid;
  logic                    err_pulse;
  logic                    err_sticky;

  modport master (
    output en,
    output in_valid,
    output d_p_in,
    output d_n_in,
    output err_clr,
    input  phase_eval,
    input  d_p_out,
    input  d_n_out,
    input  out_valid,
    input  err_pulse,
    input  err_sticky
  );

  modport slave (
    input  en,
    input  in_valid,
    input  d_p_in,
    input  d_n_in,
    input  err_clr,
    output phase_eval,
    output d_p_out,
    output d_n_out,
    output out_valid,
    output err_pulse,
    output err_sticky
  );

endinterface

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate phase controller for the WDDL XOR tree.
// IDLE -> PRE -> EVAL -> PRE ... while en is high.
module wddl_phase_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_eval,
  output logic phase_pre
);

  import wddl_pkg::*;

  phase_t state;
  phase_t state_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PH_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      PH_IDLE: state_nx = en ? PH_PRE : PH_IDLE;
      PH_PRE:  state_nx = en ? PH_EVAL : PH_IDLE;
      PH_EVAL: state_nx = en ? PH_PRE : PH_IDLE;
      default: state_nx = PH_IDLE;
    endcase
  end

  // Each decode is a single state flop bit.
  always_comb begin
    phase_eval = (state == PH_EVAL);
    phase_pre  = (state == PH_PRE);
  end

endmodule

// File: rtl/wddl_xor2.sv
// Two-input WDDL dual-rail XOR cell.
// Positive-monotone on both rails, so a 0/0 precharge wave passes through.
module wddl_xor2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_p,
  input  logic [WIDTH-1:0] a_n,
  input  logic [WIDTH-1:0] b_p,
  input  logic [WIDTH-1:0] b_n,
  output logic [WIDTH-1:0] y_p,
  output logic [WIDTH-1:0] y_n
);

  assign y_p = (a_p & b_n) | (a_n & b_p);
  assign y_n = (a_p & b_p) | (a_n & b_n);

endmodule

// File: rtl/wddl_xor_tree_pipe.sv
// Pipelined N-input WDDL dual-rail XOR reduction tree.
// One register bank per level, advancing only in EVAL phases.
module wddl_xor_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 6
) (
  input logic           clk,
  input logic           rst,
  wddl_xor_tree_pipe_if.slave bus
);

  import wddl_pkg::*;

  localparam int LEVELS = $clog2(NUM_IN);

  if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
    $error("wddl_xor_tree_pipe: NUM_IN out of range");
  end

  logic phase_eval;
  logic phase_pre;

  wddl_phase_ctrl u_phase (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .phase_eval (phase_eval),
    .phase_pre  (phase_pre)
  );

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int NI = level_size(NUM_IN, k);
    localparam int NO = half_up(NI);

    logic [WIDTH-1:0] ip   [NI];
    logic [WIDTH-1:0] in_n [NI];
    logic [WIDTH-1:0] cp   [NO];
    logic [WIDTH-1:0] cn   [NO];
    logic [WIDTH-1:0] rp   [NO];
    logic [WIDTH-1:0] rn   [NO];
    logic             vi;
    logic             v;

    if (k == 0) begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_op
        assign ip[i]   = bus.d_p_in[i*WIDTH +: WIDTH];
        assign in_n[i] = bus.d_n_in[i*WIDTH +: WIDTH];
      end
      assign vi = bus.in_valid;
    end else begin : g_src
      for (genvar i = 0; i < NI; i++) begin : g_op
        assign ip[i]   = g_lvl[k-1].rp[i];
        assign in_n[i] = g_lvl[k-1].rn[i];
      end
      assign vi = g_lvl[k-1].v;
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      if (2*j + 1 < NI) begin : g_pair
        wddl_xor2 #(.WIDTH(WIDTH)) u_xor (
          .a_p (ip[2*j]),
          .a_n (in_n[2*j]),
          .b_p (ip[2*j+1]),
          .b_n (in_n[2*j+1]),
          .y_p (cp[j]),
          .y_n (cn[j])
        );
      end else begin : g_pass
        assign cp[j] = ip[2*j];
        assign cn[j] = in_n[2*j];
      end
    end

    // Bubbles load an encoded zero so later levels stay complementary.
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        for (int j = 0; j < NO; j++) begin
          rp[j] <= '0;
          rn[j] <= '0;
        end
      end else if (phase_eval) begin
        v <= vi;
        for (int j = 0; j < NO; j++) begin
          if (k == 0 && !vi) begin
            rp[j] <= '0;
            rn[j] <= '1;
          end else begin
            rp[j] <= cp[j];
            rn[j] <= cn[j];
          end
        end
      end
    end
  end

  logic [WIDTH-1:0] last_p;
  logic [WIDTH-1:0] last_n;
  logic             last_v;

  assign last_p = g_lvl[LEVELS-1].rp[0];
  assign last_n = g_lvl[LEVELS-1].rn[0];
  assign last_v = g_lvl[LEVELS-1].v;

  assign bus.phase_eval = phase_eval;
  assign bus.d_p_out    = phase_eval ? last_p : '0;
  assign bus.d_n_out    = phase_eval ? last_n : '0;
  assign bus.out_valid  = phase_eval & last_v;

  logic det_eval;
  logic det_pre;
  logic det;
  logic err_pulse;
  logic err_sticky;

  assign det_eval = phase_eval & bus.in_valid
                  & !(&(bus.d_p_in ^ bus.d_n_in));
  assign det_pre  = phase_pre & ((|bus.d_p_in) | (|bus.d_n_in));
  assign det      = det_eval | det_pre;

  // A fresh detection outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse  <= det;
      err_sticky <= det | (err_sticky & ~bus.err_clr);
    end
  end

  assign bus.err_pulse  = err_pulse;
  assign bus.err_sticky = err_sticky;

endmodule

// File: tb/tb_wddl_xor_tree_pipe.sv
// Self-checking bench for wddl_xor_tree_pipe at NUM_IN = 6, 2 and 5.
// Expected results come from a phase model and an EVAL-sample history.
module tb_wddl_xor_tree_pipe;

  localparam int W    = 8;
  localparam int NMAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic err_clr = 1'b0;
  logic [2:0] vin = '0;
  logic [NMAX*W-1:0] dp [3];
  logic [NMAX*W-1:0] dn [3];

  always #5 clk = ~clk;

  wddl_xor_tree_pipe_if #(.WIDTH(W), .NUM_IN(6)) b6 ();
  wddl_xor_tree_pipe_if #(.WIDTH(W), .NUM_IN(2)) b2 ();
  wddl_xor_tree_pipe_if #(.WIDTH(W), .NUM_IN(5)) b5 ();

  assign b6.en = en;
  assign b2.en = en;
  assign b5.en = en;
  assign b6.err_clr = err_clr;
  assign b2.err_clr = err_clr;
  assign b5.err_clr = err_clr;
  assign b6.in_valid = vin[0];
  assign b2.in_valid = vin[1];
  assign b5.in_valid = vin[2];
  assign b6.d_p_in = dp[0][6*W-1:0];
  assign b6.d_n_in = dn[0][6*W-1:0];
  assign b2.d_p_in = dp[1][2*W-1:0];
  assign b2.d_n_in = dn[1][2*W-1:0];
  assign b5.d_p_in = dp[2][5*W-1:0];
  assign b5.d_n_in = dn[2][5*W-1:0];

  wddl_xor_tree_pipe #(.WIDTH(W), .NUM_IN(6)) u6 (
    .clk (clk), .rst (rst), .bus (b6));
  wddl_xor_tree_pipe #(.WIDTH(W), .NUM_IN(2)) u2 (
    .clk (clk), .rst (rst), .bus (b2));
  wddl_xor_tree_pipe #(.WIDTH(W), .NUM_IN(5)) u5 (
    .clk (clk), .rst (rst), .bus (b5));

  int n_chk = 0;
  int n_fail = 0;

  // Model: phase 0=idle 1=pre 2=eval; history of EVAL samples per DUT.
  int ph = 0;
  int evals [3];
  int hist [3][64];
  int nin [3] = '{6, 2, 5};
  int lv [3] = '{3, 1, 3};
  logic exp_ev;
  logic exp_ov [3];
  logic [7:0] exp_d [3];
  logic full [3];
  logic exp_pulse = 1'b0;
  logic exp_sticky = 1'b0;

  function automatic logic [7:0] xr(input logic [NMAX*W-1:0] v,
                                    input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++) r ^= v[i*W +: W];
    return r;
  endfunction

  task automatic tick();
    logic det;
    logic [7:0] x;
    int e;
    det = 1'b0;
    if (rst) begin
      ph = 0;
      exp_pulse = 1'b0;
      exp_sticky = 1'b0;
      for (int j = 0; j < 3; j++) evals[j] = 0;
    end else begin
      if (ph == 1) det = (|dp[0]) || (|dn[0]);
      if (ph == 2 && vin[0])
        for (int i = 0; i < 6*W; i++)
          if (dp[0][i] === dn[0][i]) det = 1'b1;
      if (ph == 2)
        for (int j = 0; j < 3; j++) begin
          x = xr(dp[j], nin[j]);
          hist[j][evals[j] % 64] = (vin[j] ? 256 : 0) + int'(x);
          evals[j]++;
        end
      exp_sticky = det | (exp_sticky & !err_clr);
      exp_pulse = det;
      case (ph)
        0: ph = en ? 1 : 0;
        1: ph = en ? 2 : 0;
        default: ph = en ? 1 : 0;
      endcase
    end
    @(posedge clk);
    #1;
    exp_ev = (ph == 2);
    for (int j = 0; j < 3; j++) begin
      full[j] = evals[j] >= lv[j];
      exp_ov[j] = 1'b0;
      exp_d[j] = 8'h00;
      if (exp_ev && full[j]) begin
        e = hist[j][(evals[j] - lv[j]) % 64];
        exp_ov[j] = e[8];
        exp_d[j] = e[7:0];
      end
    end
  endtask

  task automatic drive_idle();
    vin = '0;
    for (int j = 0; j < 3; j++) begin
      dp[j] = '0;
      dn[j] = '0;
    end
  endtask

  task automatic set_tok(input int j, input int i, input logic [7:0] p);
    dp[j][i*W +: W] = p;
    dn[j][i*W +: W] = ~p;
  endtask

  task automatic zero_tok(input int j);
    for (int i = 0; i < nin[j]; i++) set_tok(j, i, 8'h00);
  endtask

  task automatic wait_phase(input int t);
    for (int c = 0; c < 8 && ph != t; c++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    err_clr = 1'b0;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    en = 1'b0;
    n_chk++;
    if (b6.phase_eval !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_phase got %b want 0", b6.phase_eval);
    end
    n_chk++;
    if (b6.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid got %b want 0", b6.out_valid);
    end
    n_chk++;
    if (b6.d_p_out !== 8'h00 || b6.d_n_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 00/00",
               b6.d_p_out, b6.d_n_out);
    end
    n_chk++;
    if (b6.err_pulse !== 1'b0 || b6.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err got %b%b want 00",
               b6.err_pulse, b6.err_sticky);
    end
    tick();
    n_chk++;
    if (b6.phase_eval !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got %b want 0", b6.phase_eval);
    end
  endtask

  task automatic test_single_token();
    do_reset();
    en = 1'b1;
    wait_phase(2);
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'h01 << i);
    vin[0] = 1'b1;
    tick();
    drive_idle();
    for (int k = 1; k <= 8; k++) begin
      n_chk++;
      if (b6.out_valid !== (k == 6)) begin
        n_fail++;
        $display("FAIL single_valid k=%0d got %b want %b",
                 k, b6.out_valid, (k == 6));
      end
      n_chk++;
      if (b6.phase_eval !== (k % 2 == 0)) begin
        n_fail++;
        $display("FAIL single_phase k=%0d got %b want %b",
                 k, b6.phase_eval, (k % 2 == 0));
      end
      if (k == 6) begin
        n_chk++;
        if (b6.d_p_out !== 8'h3F || b6.d_n_out !== 8'hC0) begin
          n_fail++;
          $display("FAIL single_data got %h/%h want 3f/c0",
                   b6.d_p_out, b6.d_n_out);
        end
      end
      if (k % 2 == 1) begin
        n_chk++;
        if (b6.d_p_out !== 8'h00 || b6.d_n_out !== 8'h00) begin
          n_fail++;
          $display("FAIL single_precharge k=%0d got %h/%h want 00/00",
                   k, b6.d_p_out, b6.d_n_out);
        end
      end
      tick();
    end
  endtask

  task automatic test_pre_error();
    do_reset();
    en = 1'b1;
    wait_phase(1);
    dp[0][0] = 1'b1;
    tick();
    drive_idle();
    n_chk++;
    if (b6.err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_err_pulse got %b want 1", b6.err_pulse);
    end
    tick();
    n_chk++;
    if (b6.err_pulse !== 1'b0 || b6.err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_err_after got pulse %b sticky %b want 0 1",
               b6.err_pulse, b6.err_sticky);
    end
    repeat (3) tick();
    n_chk++;
    if (b6.err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_sticky_hold got %b want 1", b6.err_sticky);
    end
    wait_phase(1);
    dp[0][0] = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    drive_idle();
    n_chk++;
    if (b6.err_pulse !== 1'b1 || b6.err_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_err got pulse %b sticky %b want 1 1",
               b6.err_pulse, b6.err_sticky);
    end
    tick();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++;
    if (b6.err_sticky !== exp_sticky || b6.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone got %b want 0", b6.err_sticky);
    end
  endtask

  task automatic test_eval_error();
    do_reset();
    en = 1'b1;
    wait_phase(2);
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'($urandom));
    dp[0][2*W +: W] = 8'h80;
    dn[0][2*W +: W] = 8'h80;
    vin[0] = 1'b1;
    tick();
    drive_idle();
    n_chk++;
    if (b6.err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL eval_err_valid got %b want 1", b6.err_pulse);
    end
    wait_phase(2);
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'($urandom));
    dp[0][2*W +: W] = 8'h80;
    dn[0][2*W +: W] = 8'h80;
    vin[0] = 1'b0;
    tick();
    drive_idle();
    n_chk++;
    if (b6.err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL eval_err_bubble got %b want 0", b6.err_pulse);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] got [4];
    int cnt;
    cnt = 0;
    do_reset();
    en = 1'b1;
    wait_phase(2);
    zero_tok(0);
    set_tok(0, 0, 8'hFF);
    vin[0] = 1'b1;
    tick();
    drive_idle();
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if ({b6.phase_eval, b6.out_valid, b6.d_p_out, b6.d_n_out} !== '0)
      begin
        n_fail++;
        $display("FAIL freeze_out c=%0d got %b %b %h/%h want 0 0 00/00",
                 c, b6.phase_eval, b6.out_valid, b6.d_p_out, b6.d_n_out);
      end
      tick();
    end
    en = 1'b1;
    wait_phase(2);
    zero_tok(0);
    set_tok(0, 5, 8'h01);
    vin[0] = 1'b1;
    tick();
    drive_idle();
    tick();
    zero_tok(0);
    vin[0] = 1'b1;
    tick();
    drive_idle();
    for (int c = 0; c < 16; c++) begin
      if (b6.out_valid === 1'b1) begin
        if (cnt < 4) got[cnt] = b6.d_p_out;
        cnt++;
        n_chk++;
        if (b6.d_n_out !== ~b6.d_p_out) begin
          n_fail++;
          $display("FAIL freeze_rails got %h/%h want complementary",
                   b6.d_p_out, b6.d_n_out);
        end
      end
      tick();
    end
    n_chk++;
    if (cnt != 3) begin
      n_fail++;
      $display("FAIL freeze_count got %0d want 3", cnt);
    end else begin
      n_chk++;
      if (got[0] !== 8'hFF || got[1] !== 8'h01 || got[2] !== 8'h00)
      begin
        n_fail++;
        $display("FAIL freeze_order got %h %h %h want ff 01 00",
                 got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_reset_flight();
    logic [7:0] want;
    int seen_bad;
    int first;
    logic [7:0] dat;
    seen_bad = 0;
    first = -1;
    dat = 8'h00;
    do_reset();
    en = 1'b1;
    wait_phase(2);
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'($urandom));
    vin[0] = 1'b1;
    tick();
    drive_idle();
    tick();
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'($urandom));
    vin[0] = 1'b1;
    tick();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({b6.phase_eval, b6.out_valid, b6.d_p_out, b6.d_n_out,
         b6.err_pulse, b6.err_sticky} !== '0) begin
      n_fail++;
      $display("FAIL flight_reset got %b %b %h/%h %b %b want all 0",
               b6.phase_eval, b6.out_valid, b6.d_p_out, b6.d_n_out,
               b6.err_pulse, b6.err_sticky);
    end
    for (int c = 0; c < 12; c++) begin
      if (b6.out_valid !== 1'b0) seen_bad++;
      tick();
    end
    n_chk++;
    if (seen_bad != 0) begin
      n_fail++;
      $display("FAIL flight_stale got %0d valid cycles want 0", seen_bad);
    end
    wait_phase(2);
    for (int i = 0; i < 6; i++) set_tok(0, i, 8'($urandom));
    want = xr(dp[0], 6);
    vin[0] = 1'b1;
    tick();
    drive_idle();
    for (int c = 1; c <= 20; c++) begin
      if (b6.out_valid === 1'b1 && first < 0) begin
        first = c;
        dat = b6.d_p_out;
      end
      tick();
    end
    n_chk++;
    if (first != 6 || dat !== want) begin
      n_fail++;
      $display("FAIL flight_restart got cycle %0d data %h want 6 %h",
               first, dat, want);
    end
  endtask

  task automatic test_random();
    int sent;
    logic pe;
    logic ov;
    logic [7:0] po;
    logic [7:0] no;
    sent = 0;
    do_reset();
    for (int c = 0; c < 12000 && sent < 1000; c++) begin
      for (int j = 0; j < 3; j++) begin
        case (j)
          0: begin
            pe = b6.phase_eval; ov = b6.out_valid;
            po = b6.d_p_out; no = b6.d_n_out;
          end
          1: begin
            pe = b2.phase_eval; ov = b2.out_valid;
            po = b2.d_p_out; no = b2.d_n_out;
          end
          default: begin
            pe = b5.phase_eval; ov = b5.out_valid;
            po = b5.d_p_out; no = b5.d_n_out;
          end
        endcase
        n_chk++;
        if (pe !== exp_ev || ov !== exp_ov[j]) begin
          n_fail++;
          $display("FAIL rand_ctl n=%0d c=%0d got %b %b want %b %b",
                   nin[j], c, pe, ov, exp_ev, exp_ov[j]);
        end
        if (exp_ov[j]) begin
          n_chk++;
          if (po !== exp_d[j]) begin
            n_fail++;
            $display("FAIL rand_data n=%0d c=%0d got %h want %h",
                     nin[j], c, po, exp_d[j]);
          end
        end
        if (exp_ev && full[j]) begin
          n_chk++;
          if (no !== ~po) begin
            n_fail++;
            $display("FAIL rand_rails n=%0d c=%0d got %h/%h want compl",
                     nin[j], c, po, no);
          end
        end
        if (!exp_ev) begin
          n_chk++;
          if (po !== 8'h00 || no !== 8'h00) begin
            n_fail++;
            $display("FAIL rand_pre n=%0d c=%0d got %h/%h want 00/00",
                     nin[j], c, po, no);
          end
        end
      end
      n_chk++;
      if (b6.err_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL rand_err c=%0d got %b want %b",
                 c, b6.err_pulse, exp_pulse);
      end
      en = ($urandom_range(0, 9) != 0);
      drive_idle();
      if (ph == 2) begin
        for (int j = 0; j < 3; j++) begin
          vin[j] = ($urandom_range(0, 3) != 0);
          for (int i = 0; i < nin[j]; i++) set_tok(j, i, 8'($urandom));
        end
        if (vin[0]) sent++;
      end
      tick();
    end
    n_chk++;
    if (sent < 1000) begin
      n_fail++;
      $display("FAIL rand_budget got %0d tokens want 1000", sent);
    end
    n_chk++;
    if (b2.err_sticky !== 1'b0 || b5.err_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_sticky got %b %b want 0 0",
               b2.err_sticky, b5.err_sticky);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_single_token();
    test_pre_error();
    test_eval_error();
    test_freeze();
    test_reset_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
